// File: rtl/sync_fifo_pkg.sv
// Shared defaults and pointer-width helper for the single-clock byte FIFO.
package sync_fifo_pkg;

    localparam int SYNC_FIFO_DATA_W = 8;
    localparam int SYNC_FIFO_DEPTH  = 16;

    function automatic int calc_aw(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port storage: synchronous write port, registered read port.
// The read register clears on rst so the FIFO output starts at zero; the array itself is never cleared.
module sync_fifo_ram
    import sync_fifo_pkg::*;
#(
    parameter int DATA_W = SYNC_FIFO_DATA_W,
    parameter int DEPTH  = SYNC_FIFO_DEPTH,
    parameter int AW     = calc_aw(SYNC_FIFO_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Holds its last value whenever no read is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (re) begin
            r_rdata <= r_mem[raddr];
        end
    end

    assign rdata = r_rdata;

endmodule

// File: rtl/sync_fifo_gen.sv
// Single-clock byte FIFO with standard (one-cycle latency) read timing and registered flags.
// Define SYNC_FIFO_STATUS_EN to add data_count, overflow and underflow outputs.
module sync_fifo_gen
    import sync_fifo_pkg::*;
#(
    parameter  int DATA_W = SYNC_FIFO_DATA_W,
    parameter  int DEPTH  = SYNC_FIFO_DEPTH,
    localparam int AW     = calc_aw(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              wr_en,
    input  logic              rd_en,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
`ifdef SYNC_FIFO_STATUS_EN
    ,
    output logic [AW:0]       data_count,
    output logic              overflow,
    output logic              underflow
`endif
);

    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_cnt;
    logic          r_full;
    logic          r_empty;

    logic          w_wr_acc;
    logic          w_rd_acc;
    logic [AW:0]   w_cnt_next;

    // Acceptance is qualified by the registered flags, so a full/empty FIFO
    // never lets the opposite-side request sneak through in the same cycle.
    assign w_wr_acc = wr_en & ~r_full;
    assign w_rd_acc = rd_en & ~r_empty;

    always_comb begin
        w_cnt_next = r_cnt;
        case ({w_wr_acc, w_rd_acc})
            2'b10:   w_cnt_next = r_cnt + 1'b1;
            2'b01:   w_cnt_next = r_cnt - 1'b1;
            default: w_cnt_next = r_cnt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_cnt   <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            if (w_wr_acc) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_cnt   <= w_cnt_next;
            r_full  <= (w_cnt_next == CNT_FULL);
            r_empty <= (w_cnt_next == '0);
        end
    end

    sync_fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_ram (
        .clk    (clk),
        .rst    (rst),
        .we     (w_wr_acc),
        .waddr  (r_wptr),
        .wdata  (din),
        .re     (w_rd_acc),
        .raddr  (r_rptr),
        .rdata  (dout)
    );

    assign full  = r_full;
    assign empty = r_empty;

`ifdef SYNC_FIFO_STATUS_EN
    logic r_overflow;
    logic r_underflow;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= wr_en & r_full;
            r_underflow <= rd_en & r_empty;
        end
    end

    assign data_count = r_cnt;
    assign overflow   = r_overflow;
    assign underflow  = r_underflow;
`endif

endmodule

// File: tb/tb_sync_fifo_gen.sv
// Directed bench for sync_fifo_gen: stimulus pushes expected read data into a queue,
// a negedge monitor pops and compares dout one cycle after each accepted read.
module tb_sync_fifo_gen;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic       rd_en;
    logic [7:0] din;
    logic [7:0] dout;
    logic       full;
    logic       empty;
`ifdef SYNC_FIFO_STATUS_EN
    logic [4:0] data_count;
    logic       overflow;
    logic       underflow;
`endif

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] model_q[$];
    logic [7:0] exp_q[$];
    logic       chk_rd = 1'b0;

    always #5 clk = ~clk;

    sync_fifo_gen dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .dout       (dout),
        .full       (full),
        .empty      (empty)
`ifdef SYNC_FIFO_STATUS_EN
        ,
        .data_count (data_count),
        .overflow   (overflow),
        .underflow  (underflow)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // One clock of stimulus; the model decides acceptance from its pre-edge occupancy.
    task automatic cycle(input logic r, input logic w, input logic rd, input logic [7:0] d);
        logic       acc_w;
        logic       acc_r;
        logic [7:0] v;
        int         sz_before;
        rst   = r;
        wr_en = w;
        rd_en = rd;
        din   = d;
        sz_before = model_q.size();
        acc_w = !r && w  && (sz_before < DEPTH);
        acc_r = !r && rd && (sz_before > 0);
        @(posedge clk);
        #1;
        if (r) begin
            model_q.delete();
            exp_q.delete();
            chk_rd = 1'b0;
        end else begin
            if (acc_r) begin
                v = model_q.pop_front();
                exp_q.push_back(v);
            end
            if (acc_w) model_q.push_back(d);
            chk_rd = acc_r;
        end
        chk("empty", empty, model_q.size() == 0);
        chk("full",  full,  model_q.size() == DEPTH);
`ifdef SYNC_FIFO_STATUS_EN
        chk("data_count", data_count, model_q.size());
        chk("overflow",   overflow,   !r && w  && (sz_before == DEPTH));
        chk("underflow",  underflow,  !r && rd && (sz_before == 0));
`endif
    endtask

    always @(negedge clk) begin
        logic [7:0] e;
        if (chk_rd) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL rd_data: got %02h, expected no read", dout);
            end else begin
                e = exp_q.pop_front();
                $display("rd: dout=%02h expected=%02h", dout, e);
                chk("rd_data", dout, e);
            end
        end
    end

    initial begin
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; din = '0;

        // Reset with both requests active: nothing may be written.
        cycle(1, 1, 1, 8'h55);
        chk("rst_dout", dout, 8'h00);
        cycle(1, 1, 1, 8'h55);
        chk("rst_dout", dout, 8'h00);
        cycle(0, 0, 0, 8'h00);

        // Single word
        cycle(0, 1, 0, 8'hA5);
        cycle(0, 0, 1, 8'h00);
        cycle(0, 0, 0, 8'h00);

        // Fill, overflow attempt (with a concurrent read request), drain
        for (int i = 0; i < DEPTH; i++) cycle(0, 1, 0, 8'(i));
        cycle(0, 1, 1, 8'hFF);
        for (int i = 0; i < DEPTH; i++) cycle(0, 0, 1, 8'h00);
        cycle(0, 0, 0, 8'h00);

        // Streaming across pointer wrap
        cycle(1, 0, 0, 8'h00);
        for (int i = 0; i < 45; i++) cycle(0, 1, 1, 8'(i + 1));
        cycle(0, 0, 1, 8'h00);
        cycle(0, 0, 0, 8'h00);

        // Empty read holds dout; a write alongside an empty read still lands
        cycle(0, 1, 0, 8'h3C);
        cycle(0, 0, 1, 8'h00);
        cycle(0, 0, 1, 8'h00);
        chk("hold_dout", dout, 8'h3C);
        cycle(0, 1, 1, 8'h11);
        chk("hold_dout", dout, 8'h3C);
        cycle(0, 0, 1, 8'h00);
        cycle(0, 0, 0, 8'h00);

        // Mid-operation reset discards queued data
        for (int i = 0; i < 5; i++) cycle(0, 1, 0, 8'(8'h40 + i));
        cycle(1, 1, 1, 8'h99);
        chk("midrst_dout", dout, 8'h00);
        cycle(0, 1, 0, 8'h77);
        cycle(0, 0, 1, 8'h00);
        cycle(0, 0, 0, 8'h00);

        @(negedge clk);
        chk("sb_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sync_fifo_gen.md
Name: sync_fifo_gen

Overview:
Single-clock, first-in-first-out byte buffer with standard (non-first-word-fall-through) read timing.
- Decouples a producer and a consumer that share one clock domain.
- Provides full/empty flow-control flags.
- Drop-in buffer between byte-stream stages; it is the single-clock stand-in for the vendor FIFO core used on the byte datapath.

Parameters:
- DATA_W, 8, width of din/dout in bits.
- DEPTH, 16, number of storage entries; must be a power of 2, minimum 4.
- AW, $clog2(DEPTH), derived pointer width; not overridable.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- din  input  DATA_W  write data.
- wr_en  input  1  write request.
- rd_en  input  1  read request.
- dout  output  DATA_W  registered read data.
- full  output  1  no free entries.
- empty  output  1  no stored entries.

Behaviour:
- Storage: DEPTH x DATA_W array. Write pointer wptr and read pointer rptr are AW bits, wrap modulo DEPTH. Occupancy counter cnt is AW+1 bits, range 0..DEPTH.
- Reset (rst=1 at a clk edge): wptr=0, rptr=0, cnt=0, dout=0, empty=1, full=0. Memory contents are not cleared. Reset overrides any concurrent wr_en/rd_en.
- Write accept: wr_en=1 and full=0. mem[wptr] <= din; wptr increments.
- Write when full: ignored, even if rd_en=1 in the same cycle. No data corruption, no pointer change.
- Read accept: rd_en=1 and empty=0. dout <= mem[rptr]; rptr increments. Read latency is 1 cycle: data appears on dout the cycle after the accepting edge.
- Read when empty: ignored, even if wr_en=1 in the same cycle. dout holds its last value.
- Counter update:
  - Accepted write only: cnt+1.
  - Accepted read only: cnt-1.
  - Both accepted: cnt unchanged; both pointers advance.
- Flags are registered outputs, updated on the same edge as cnt:
  - empty = (next cnt == 0).
  - full = (next cnt == DEPTH).
  - empty and full are never both 1.
- Write-then-read latency: a word written at edge N is readable (empty deasserts) after edge N. A read accepted at edge N+1 puts the word on dout after edge N+1.
- Ordering: strict FIFO; output order equals accepted input order across pointer wrap.
- Reset mid-operation: all queued data is discarded; state returns to the reset values above on the next edge.

Optional Feature:
Macro SYNC_FIFO_STATUS_EN.
- Defined, the block adds three outputs:
  - data_count [AW:0]: equals cnt.
  - overflow [1]: one-cycle registered pulse when a write is ignored because full=1.
  - underflow [1]: one-cycle registered pulse when a read is ignored because empty=1.
  - All three reset to 0.
- Not defined: these ports and their logic do not exist; core behaviour is identical.

Decomposition:
- Package sync_fifo_pkg holds the DATA_W and DEPTH default constants and a localparam function computing AW.
- Sub-module sync_fifo_ram: simple dual-port array with synchronous write port (we, waddr, wdata) and registered read port (re, raddr, rdata).
- Top sync_fifo_gen holds the pointers, counter, flags, and the optional status logic.

Test Plan:
- Reset: assert rst for 2 cycles with wr_en=rd_en=1 -> empty=1, full=0, dout=0; no write takes effect.
- Single word: write 0xA5 one cycle -> empty=0 next cycle; rd_en one cycle -> dout=0xA5 one cycle later, then empty=1.
- Fill: write 0x00..0x0F (DEPTH=16) -> full=1 after the 16th write. A 17th write of 0xFF is ignored (overflow=1 with SYNC_FIFO_STATUS_EN). Drain returns 0x00..0x0F in order, then empty=1.
- Streaming: after reset release, write din incrementing from 0x01 every cycle with rd_en=1 every cycle -> dout follows 0x01, 0x02, ... with 2-cycle lag; no overflow, count stays at most 1; ordering holds across pointer wrap (>40 words).
- Empty read: rd_en=1 while empty with dout=0x3C -> dout stays 0x3C, pointers unchanged, underflow pulse when enabled.
- Mid-operation reset: 5 words queued, assert rst -> empty=1, full=0, dout=0; a subsequent write of 0x77 then read returns 0x77.
